axil_adder_master: RTL
======================

# axil_adder_master

AXI4-Lite master that drives the memory-mapped adder slave from a simple command/response stream. Each accepted operand pair is written to the slave's two addend registers, then the sum and extension registers are read back and returned as one response. It sits directly upstream of the adder slave. It owns the m00 side of the AXI-Lite link that the slave exposes as s00, and it obeys every handshake rule the slave-side protocol checkers enforce.

## Interface
Parameters:
- C_M00_BASEADDR, 32'h0000_0000, slave base address. Register offsets: +0 addend 0, +4 addend 1, +8 sum, +12 extension.

Ports:
- axi_aclk, in, 1, sole clock; all logic on rising edge.
- m00_axi_aresetn, in, 1, reset; one clock, synchronous, active-low.
- cmd_valid / cmd_ready, in / out, 1 each, command handshake.
- cmd_a, cmd_b, in, 32 each, operands.
- rsp_valid / rsp_ready, out / in, 1 each, response handshake.
- rsp_sum, out, 32, rdata of the +8 read.
- rsp_ovf, out, 1, bit 31 of the rdata of the +12 read.
- rsp_err, out, 1, set if any bresp or rresp of the transaction was not 2'b00.
- txn_count, out, 16, count of completed responses; wraps at 0xFFFF→0.
- m00_axi_awaddr, m00_axi_awvalid, m00_axi_awready: out 32, out 1, in 1.
- m00_axi_wdata, m00_axi_wvalid, m00_axi_wready: out 32, out 1, in 1.
- m00_axi_bresp, m00_axi_bvalid, m00_axi_bready: in 2, in 1, out 1.
- m00_axi_araddr, m00_axi_arvalid, m00_axi_arready: out 32, out 1, in 1.
- m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid, m00_axi_rready: in 32, in 2, in 1, out 1.

## Operation
- FSM states: IDLE → WR0 → B0 → WR1 → B1 → RD2 → R2 → RD3 → R3 → RSP → IDLE.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_a and cmd_b, clear the internal error flag, go to WR0.
- **WR0 / WR1**
  - On entry, awvalid=1 and wvalid=1 in the same cycle.
  - awaddr is base+0 (WR0) or base+4 (WR1); wdata is cmd_a or cmd_b.
  - Each valid drops independently on the edge its ready is seen.
  - Exit to B0/B1 on the edge where both handshakes are complete, whether simultaneous or in either order.
- **B0 / B1**
  - bready=1.
  - On bvalid, OR (bresp≠00) into the error flag and advance.
- **RD2 / RD3**
  - arvalid=1, araddr=base+8 or base+12.
  - Advance on arready.
- **R2 / R3**
  - rready=1.
  - On rvalid, capture rdata (R2: full word to rsp_sum; R3: bit 31 to rsp_ovf), OR (rresp≠00) into the error flag, advance.
- **RSP**
  - rsp_valid=1 with rsp_sum, rsp_ovf, rsp_err stable.
  - On rsp_ready: txn_count+1, go to IDLE.
- Error responses never abort: all four accesses always execute.
- Valid-stability rules:
  - A valid once raised is never lowered before its ready.
  - awaddr, wdata and araddr change only on the edge where the matching valid rises; otherwise they hold their value, including while the valid is low.
  - araddr holds through the following R phase.
- All AXI and response outputs are registered; no combinational path from any input to any output.

## Timing
- Reset (m00_axi_aresetn=0 at an edge), taking effect that edge:
  - FSM=IDLE.
  - Zero: all valid outputs, bready, rready, rsp_valid, rsp_sum, rsp_ovf, rsp_err, txn_count, awaddr, wdata, araddr.
  - cmd_ready=1 from the first edge after reset releases.
- Reset mid-transaction abandons the transaction: no response, no count increment.
- Each state's outputs appear the cycle after the edge that entered the state.
- With a zero-wait slave (ready in the first valid cycle; bvalid/rvalid the cycle after the address or data handshake):
  - cmd accept at edge E0; handshakes at E1..E8; rsp_valid high after E8.
  - Minimum latency: 8 cycles. Throughput: 1 command per ≥10 cycles.
- A new cmd is accepted at the earliest on the edge after rsp_ready handshake (cmd_ready=0 outside IDLE).
- rsp_valid held with stable data for any number of cycles while rsp_ready=0.
- No timeout: the FSM waits indefinitely for slave handshakes.

## Test plan
- cmd_a=5, cmd_b=7, zero-wait slave → writes 5@base+0 and 7@base+4; rsp_sum=12, rsp_ovf=0, rsp_err=0; rsp_valid 8 cycles after accept; txn_count=1.
- Overflow cases:
  - 0x7FFF_FFFF + 0x0000_0001 → rsp_sum=0x8000_0000, rsp_ovf=1.
  - 0x8000_0000 + 0x8000_0000 → rsp_sum=0, rsp_ovf=1.
- Slave holds awready low 3 cycles with wready immediate → wvalid drops after 1 cycle; awvalid and awaddr stay stable until the handshake; FSM reaches B0 only after both handshakes.
- bresp=2'b10 on the first write → all remaining accesses still issued; rsp_err=1. Next clean command → rsp_err=0.
- rsp_ready low for 5 cycles → rsp_valid, rsp_sum, rsp_ovf held; cmd_ready=0; txn_count increments once. Preload txn_count to 0xFFFF → wraps to 0.
- Reset asserted during R2 → next edge all valids, bready, rready, rsp_valid and txn_count are 0; FSM in IDLE; no response; next command completes normally.

Source files
------------

// File: rtl/axil_adder_master_if.sv
// AXI4-Lite link between axil_adder_master (master side) and the adder
// slave (slave side).
//   aw*: write address channel     w*: write data channel
//   b* : write response channel    ar*: read address channel
//   r* : read data channel
interface axil_adder_master_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_adder_master.sv
// AXI4-Lite master for the memory-mapped adder slave. Each accepted command
// writes cmd_a to base+0 and cmd_b to base+4, then reads the sum (base+8)
// and extension (base+12) registers and returns them as one response.
// Ports:
//   axi_aclk, m00_axi_aresetn   clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_a/cmd_b           command stream
//   rsp_valid/rsp_ready, rsp_sum/ovf/err       response stream
//   txn_count                                  completed responses (wraps)
//   m00_axi                                    AXI4-Lite master port
// All outputs are registered.
module axil_adder_master #(
  parameter logic [31:0] C_M00_BASEADDR = 32'h0000_0000
) (
  input  logic                axi_aclk,
  input  logic                m00_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_a,
  input  logic [31:0]         cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_sum,
  output logic                rsp_ovf,
  output logic                rsp_err,
  output logic [15:0]         txn_count,
  axil_adder_master_if.master m00_axi
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR0, S_B0, S_WR1, S_B1, S_RD2, S_R2, S_RD3, S_R3, S_RSP
  } state_t;

  state_t      r_state, w_state_next;

  logic        r_cmd_ready;
  logic [31:0] r_b;
  logic        r_err;
  logic [31:0] r_awaddr, r_wdata, r_araddr;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic        r_rsp_valid;
  logic [31:0] r_sum;
  logic        r_ovf;
  logic [15:0] r_txn_count;

  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic        w_wr_done;

  assign w_aw_hs = r_awvalid & m00_axi.awready;
  assign w_w_hs  = r_wvalid  & m00_axi.wready;
  assign w_b_hs  = r_bready  & m00_axi.bvalid;
  assign w_ar_hs = r_arvalid & m00_axi.arready;
  assign w_r_hs  = r_rready  & m00_axi.rvalid;
  // Both write channels are complete once each valid has either already
  // dropped or is being accepted this edge, in whichever order they occur.
  assign w_wr_done = (!r_awvalid | m00_axi.awready) & (!r_wvalid | m00_axi.wready);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (cmd_valid && r_cmd_ready) w_state_next = S_WR0;
      S_WR0:  if (w_wr_done)                w_state_next = S_B0;
      S_B0:   if (w_b_hs)                   w_state_next = S_WR1;
      S_WR1:  if (w_wr_done)                w_state_next = S_B1;
      S_B1:   if (w_b_hs)                   w_state_next = S_RD2;
      S_RD2:  if (w_ar_hs)                  w_state_next = S_R2;
      S_R2:   if (w_r_hs)                   w_state_next = S_RD3;
      S_RD3:  if (w_ar_hs)                  w_state_next = S_R3;
      S_R3:   if (w_r_hs)                   w_state_next = S_RSP;
      S_RSP:  if (r_rsp_valid && rsp_ready) w_state_next = S_IDLE;
      default:                              w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!m00_axi_aresetn) r_state <= S_IDLE;
    else                  r_state <= w_state_next;
  end

  always_ff @(posedge axi_aclk) begin
    if (!m00_axi_aresetn) begin
      r_cmd_ready <= 1'b0;
      r_b         <= '0;
      r_err       <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_txn_count <= '0;
    end else begin
      // Level outputs are registered decodes of the next state so they
      // appear the cycle after the state is entered.
      r_cmd_ready <= (w_state_next == S_IDLE);
      r_bready    <= (w_state_next == S_B0) || (w_state_next == S_B1);
      r_rready    <= (w_state_next == S_R2) || (w_state_next == S_R3);

      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
      if (w_ar_hs) r_arvalid <= 1'b0;

      unique case (r_state)
        S_IDLE: if (w_state_next == S_WR0) begin
          r_b       <= cmd_b;
          r_err     <= 1'b0;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_awaddr  <= C_M00_BASEADDR;
          r_wdata   <= cmd_a;
        end
        S_B0: if (w_b_hs) begin
          r_err     <= r_err | (m00_axi.bresp != 2'b00);
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_awaddr  <= C_M00_BASEADDR + 32'd4;
          r_wdata   <= r_b;
        end
        S_B1: if (w_b_hs) begin
          r_err     <= r_err | (m00_axi.bresp != 2'b00);
          r_arvalid <= 1'b1;
          r_araddr  <= C_M00_BASEADDR + 32'd8;
        end
        S_R2: if (w_r_hs) begin
          r_err     <= r_err | (m00_axi.rresp != 2'b00);
          r_sum     <= m00_axi.rdata;
          r_arvalid <= 1'b1;
          r_araddr  <= C_M00_BASEADDR + 32'd12;
        end
        S_R3: if (w_r_hs) begin
          r_err       <= r_err | (m00_axi.rresp != 2'b00);
          r_ovf       <= m00_axi.rdata[31];
          r_rsp_valid <= 1'b1;
        end
        S_RSP: if (r_rsp_valid && rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_txn_count <= r_txn_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_sum         = r_sum;
  assign rsp_ovf         = r_ovf;
  assign rsp_err         = r_err;
  assign txn_count       = r_txn_count;
  assign m00_axi.awaddr  = r_awaddr;
  assign m00_axi.awvalid = r_awvalid;
  assign m00_axi.wdata   = r_wdata;
  assign m00_axi.wvalid  = r_wvalid;
  assign m00_axi.bready  = r_bready;
  assign m00_axi.araddr  = r_araddr;
  assign m00_axi.arvalid = r_arvalid;
  assign m00_axi.rready  = r_rready;

endmodule
